// File: rtl/crop_engine.sv
// Streams a rectangular window of a BMP-style source image into a destination
// memory, rewriting the width/height header fields and padding each output row.
module crop_engine #(
    parameter int unsigned SRC_W     = 256,
    parameter int unsigned SRC_H     = 256,
    parameter int unsigned CH        = 3,
    parameter int unsigned HDR_BYTES = 54,
    parameter int unsigned PAD_ROWS  = 1,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned COORD_W   = 16
) (
    input  logic               CLOCK_50,
    input  logic [3:0]         KEY,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [7:0]         rd_data,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [7:0]         wr_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COORD_W-1:0] out_w,
    output logic [COORD_W-1:0] out_h
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_HDR, S_ROW, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic              valid;
        logic              use_rd;
        logic [7:0]        sub;
        logic [ADDR_W-1:0] addr;
    } pipe_t;

    localparam logic [ADDR_W-1:0] HDR_LAST = ADDR_W'(HDR_BYTES - 1);
    localparam logic [ADDR_W-1:0] W_FIELD  = ADDR_W'(18);
    localparam logic [ADDR_W-1:0] H_FIELD  = ADDR_W'(22);
    localparam logic [ADDR_W-1:0] F_END    = ADDR_W'(26);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W * CH);

    logic rst_n;
    logic unused_keys;
    assign rst_n       = KEY[3];
    assign unused_keys = ^KEY[2:0];

    state_t              state_q, state_d;
    logic [COORD_W-1:0]  x0_q, y0_q, w_q, h_q, out_w_q, out_h_q, row_r;
    logic                err_q;
    logic [ADDR_W-1:0]   dst_ptr, col_b, src_row;
    logic [2:0]          dcnt;
    pipe_t [RD_LAT:0]    pipe_q;

    logic                bad, accept, row_end, is_field;
    logic [31:0]         rem_w, rem_h, fld_val;
    logic [COORD_W-1:0]  clamp_w, clamp_h;
    logic [ADDR_W-1:0]   src_start, row_bytes, row_bytes_p3, stride, fld_off;
    logic [7:0]          fld_byte;
    logic                iss_valid, iss_rd, iss_use;
    logic [7:0]          iss_sub;
    logic [ADDR_W-1:0]   iss_src;
    pipe_t               iss_entry;

    assign bad     = (32'(x0_q) >= SRC_W) || (32'(y0_q) >= SRC_H) || (w_q == '0) || (h_q == '0);
    assign rem_w   = SRC_W - 32'(x0_q);
    assign rem_h   = SRC_H - 32'(y0_q);
    assign clamp_w = (32'(w_q) < rem_w) ? w_q : COORD_W'(rem_w);
    assign clamp_h = (32'(h_q) < rem_h) ? h_q : COORD_W'(rem_h);

    assign src_start    = ADDR_W'(HDR_BYTES)
                        + (ADDR_W'(y0_q) * ADDR_W'(SRC_W) + ADDR_W'(x0_q)) * ADDR_W'(CH);
    assign row_bytes    = ADDR_W'(out_w_q) * ADDR_W'(CH);
    assign row_bytes_p3 = row_bytes + ADDR_W'(3);
    assign stride       = (PAD_ROWS != 0) ? {row_bytes_p3[ADDR_W-1:2], 2'b00} : row_bytes;

    // Header bytes 18..25 carry the clamped size as two little-endian 32-bit words.
    assign is_field = (dst_ptr >= W_FIELD) && (dst_ptr < F_END);
    assign fld_off  = dst_ptr - W_FIELD;
    assign fld_val  = (dst_ptr >= H_FIELD) ? 32'(out_h_q) : 32'(out_w_q);
    assign fld_byte = 8'(fld_val >> {fld_off[1:0], 3'b000});

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d   = state_q;
        accept    = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = 1'b0;
        iss_use   = 1'b0;
        iss_sub   = '0;
        iss_src   = '0;
        row_end   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CHECK;
                    accept  = 1'b1;
                end
            end
            S_CHECK: state_d = bad ? S_DRAIN : S_HDR;
            S_HDR: begin
                iss_valid = 1'b1;
                iss_rd    = 1'b1;
                iss_src   = dst_ptr;
                if (is_field) iss_sub = fld_byte;
                else          iss_use = 1'b1;
                if (dst_ptr == HDR_LAST) state_d = S_ROW;
            end
            S_ROW: begin
                iss_valid = 1'b1;
                if (col_b < row_bytes) begin
                    iss_rd  = 1'b1;
                    iss_use = 1'b1;
                    iss_src = src_row + col_b;
                end
                row_end = (col_b == stride - ADDR_W'(1));
                if (row_end && (row_r == out_h_q - COORD_W'(1))) state_d = S_DRAIN;
            end
            S_DRAIN: if (dcnt == 3'(RD_LAT)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign iss_entry = '{valid: iss_valid, use_rd: iss_use, sub: iss_sub, addr: dst_ptr};

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            out_w_q <= '0;
            out_h_q <= '0;
            row_r   <= '0;
            err_q   <= 1'b0;
            dst_ptr <= '0;
            col_b   <= '0;
            src_row <= '0;
            dcnt    <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            // NOTE: the delay pipe holds valid bits, so it is reset like any control flop.
            pipe_q  <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every flop sees pre-edge values of the others.
            rd_en  <= iss_rd;
            if (iss_rd) rd_addr <= iss_src;
            pipe_q <= {pipe_q[RD_LAT-1:0], iss_entry};
            if (iss_valid) dst_ptr <= dst_ptr + ADDR_W'(1);
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        x0_q  <= x0;
                        y0_q  <= y0;
                        w_q   <= w;
                        h_q   <= h;
                        err_q <= 1'b0;
                    end
                end
                S_CHECK: begin
                    dst_ptr <= '0;
                    col_b   <= '0;
                    row_r   <= '0;
                    src_row <= src_start;
                    if (bad) begin
                        err_q   <= 1'b1;
                        out_w_q <= '0;
                        out_h_q <= '0;
                        dcnt    <= 3'(RD_LAT);
                    end else begin
                        out_w_q <= clamp_w;
                        out_h_q <= clamp_h;
                        dcnt    <= '0;
                    end
                end
                S_ROW: begin
                    if (row_end) begin
                        col_b   <= '0;
                        row_r   <= row_r + COORD_W'(1);
                        src_row <= src_row + ROW_STEP;
                    end else begin
                        col_b <= col_b + ADDR_W'(1);
                    end
                end
                S_DRAIN: dcnt <= dcnt + 3'd1;
                default: ;
            endcase
        end
    end

    assign wr_en   = pipe_q[RD_LAT].valid;
    assign wr_addr = pipe_q[RD_LAT].addr;
    assign wr_data = pipe_q[RD_LAT].use_rd ? rd_data : pipe_q[RD_LAT].sub;
    assign busy    = (state_q == S_CHECK) || (state_q == S_HDR) || (state_q == S_ROW)
                   || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign err     = err_q;
    assign out_w   = out_w_q;
    assign out_h   = out_h_q;

endmodule
